// File: rtl/micro_board_evaluator_pkg.sv
// Shared encodings for the micro board evaluator: results, FSM states, line table.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package micro_board_evaluator_pkg;

   localparam int NUM_CELLS = 9;
   localparam int NUM_LINES = 8;

   // Result / cell encodings; DRAW doubles as "both players won".
   localparam logic [1:0] RES_ONGOING = 2'b00;
   localparam logic [1:0] RES_P1      = 2'b01;
   localparam logic [1:0] RES_P2      = 2'b10;
   localparam logic [1:0] RES_DRAW    = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_CAPT  = 3'd2,
      ST_EVAL  = 3'd3,
      ST_WRITE = 3'd4
   } state_e;

   // Winning lines as 1-based cell numbers: rows, columns, diagonals.
   localparam int WIN_LINES [NUM_LINES][3] = '{
      '{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9},
      '{1, 4, 7}, '{2, 5, 8}, '{3, 6, 9},
      '{1, 5, 9}, '{3, 5, 7}
   };

   // Cell idx (1..9) lives at bits [2*(idx-1) +: 2] of a packed board.
   function automatic logic [1:0] cell_of(input logic [2*NUM_CELLS-1:0] cells, input int idx);
      return cells[2*(idx-1) +: 2];
   endfunction

   function automatic logic macro_addr_ok(input logic [3:0] a);
      return (a >= 4'd1) && (a <= 4'd9);
   endfunction

endpackage

// File: rtl/micro_board_evaluator_win.sv
// micro_win_check: maps a packed 3x3 board of 2-bit cells to a 2-bit result.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; usable for the micro boards and for the macro board alike.
module micro_win_check
   import micro_board_evaluator_pkg::*;
(
   input  logic [2*NUM_CELLS-1:0] cells,
   output logic [1:0]             result
);

   logic p1_win;
   logic p2_win;
   logic full;

   // Look for a line owned entirely by one player and note whether every cell is taken.
   always_comb begin
      p1_win = 1'b0;
      p2_win = 1'b0;
      full   = 1'b1;
      for (int l = 0; l < NUM_LINES; l++) begin
         if (cell_of(cells, WIN_LINES[l][0]) == RES_P1 &&
             cell_of(cells, WIN_LINES[l][1]) == RES_P1 &&
             cell_of(cells, WIN_LINES[l][2]) == RES_P1)
            p1_win = 1'b1;
         if (cell_of(cells, WIN_LINES[l][0]) == RES_P2 &&
             cell_of(cells, WIN_LINES[l][1]) == RES_P2 &&
             cell_of(cells, WIN_LINES[l][2]) == RES_P2)
            p2_win = 1'b1;
      end
      for (int c = 1; c <= NUM_CELLS; c++) begin
         if (cell_of(cells, c) == RES_ONGOING)
            full = 1'b0;
      end
      if (p1_win && p2_win)
         result = RES_DRAW;
      else if (p1_win)
         result = RES_P1;
      else if (p2_win)
         result = RES_P2;
      else if (full)
         result = RES_DRAW;
      else
         result = RES_ONGOING;
   end

endmodule

// File: rtl/micro_board_evaluator.sv
// Reads the 9 cells of one micro board, evaluates it and writes the result to the board-state RAM.
// Latency: start at cycle 0 -> done/state_we at cycle 12; next start accepted at cycle 13.
// Backpressure: none; start while busy (including the WRITE cycle) is dropped, not queued.
module micro_board_evaluator
   import micro_board_evaluator_pkg::*;
#(
   parameter bit WRITE_ONGOING = 1'b1
) (
   input  logic       clk,
   input  logic       clear_n,
   input  logic       start,
   input  logic [3:0] macro_addr,
   input  logic [1:0] cell_rdata,
   output logic [3:0] macro_sel,
   output logic [3:0] cell_addr,
   output logic       state_we,
   output logic [3:0] state_addr,
   output logic [1:0] state_data,
   output logic [1:0] result,
   output logic       busy,
   output logic       done
);

   state_e                 state_q,      state_d;
   logic [3:0]             macro_sel_q,  macro_sel_d;
   logic [3:0]             cell_addr_q,  cell_addr_d;
   logic [2*NUM_CELLS-1:0] shadow_q,     shadow_d;
   logic [1:0]             result_q,     result_d;
   logic [1:0]             state_data_q, state_data_d;
   logic                   state_we_q,   state_we_d;
   logic                   busy_q,       busy_d;
   logic                   done_q,       done_d;

   logic [1:0]             win_res;

   micro_win_check u_win_check (
      .cells  (shadow_q),
      .result (win_res)
   );

   // Next-state and next-output logic; every output is registered.
   always_comb begin
      state_d      = state_q;
      macro_sel_d  = macro_sel_q;
      cell_addr_d  = cell_addr_q;
      shadow_d     = shadow_q;
      result_d     = result_q;
      state_data_d = state_data_q;
      state_we_d   = 1'b0;
      done_d       = 1'b0;
      busy_d       = busy_q;

      case (state_q)
         ST_IDLE: begin
            cell_addr_d = 4'd0;
            busy_d      = 1'b0;
            if (start) begin
               if (macro_addr_ok(macro_addr)) begin
                  macro_sel_d = macro_addr;
                  shadow_d    = '0;
                  cell_addr_d = 4'd1;
                  busy_d      = 1'b1;
                  state_d     = ST_FETCH;
               end else begin
                  // Out-of-range board: acknowledge without touching any state.
                  done_d = 1'b1;
               end
            end
         end

         ST_FETCH: begin
            // Read data lags the address by one cycle, so capture the previous cell.
            if (cell_addr_q >= 4'd2)
               shadow_d[2*(int'(cell_addr_q)-2) +: 2] = cell_rdata;
            if (cell_addr_q == 4'd9) begin
               cell_addr_d = 4'd0;
               state_d     = ST_CAPT;
            end else begin
               cell_addr_d = cell_addr_q + 4'd1;
            end
         end

         ST_CAPT: begin
            shadow_d[2*NUM_CELLS-1 -: 2] = cell_rdata;
            state_d                      = ST_EVAL;
         end

         ST_EVAL: begin
            result_d     = win_res;
            state_data_d = win_res;
            done_d       = 1'b1;
            state_we_d   = !((win_res == RES_ONGOING) && !WRITE_ONGOING);
            state_d      = ST_WRITE;
         end

         ST_WRITE: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            cell_addr_d = 4'd0;
            busy_d      = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // FSM and output registers; clear_n aborts any evaluation in flight.
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state_q      <= ST_IDLE;
         macro_sel_q  <= '0;
         cell_addr_q  <= '0;
         shadow_q     <= '0;
         result_q     <= '0;
         state_data_q <= '0;
         state_we_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         macro_sel_q  <= macro_sel_d;
         cell_addr_q  <= cell_addr_d;
         shadow_q     <= shadow_d;
         result_q     <= result_d;
         state_data_q <= state_data_d;
         state_we_q   <= state_we_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign macro_sel  = macro_sel_q;
   assign cell_addr  = cell_addr_q;
   assign state_we   = state_we_q;
   assign state_addr = macro_sel_q;
   assign state_data = state_data_q;
   assign result     = result_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_micro_board_evaluator.sv
module tb_micro_board_evaluator;

   logic       clk = 1'b0;
   logic       clear_n;
   logic       start;
   logic [3:0] macro_addr;

   logic [1:0] rdata1, rdata0;
   logic [3:0] msel1, msel0, caddr1, caddr0, saddr1, saddr0;
   logic       we1, we0, busy1, busy0, done1, done0;
   logic [1:0] sdata1, sdata0, res1, res0;

   logic [1:0] board_mem [16][16];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   micro_board_evaluator #(.WRITE_ONGOING(1'b1)) dut_wo1 (
      .clk(clk), .clear_n(clear_n), .start(start), .macro_addr(macro_addr),
      .cell_rdata(rdata1), .macro_sel(msel1), .cell_addr(caddr1), .state_we(we1),
      .state_addr(saddr1), .state_data(sdata1), .result(res1), .busy(busy1), .done(done1)
   );

   micro_board_evaluator #(.WRITE_ONGOING(1'b0)) dut_wo0 (
      .clk(clk), .clear_n(clear_n), .start(start), .macro_addr(macro_addr),
      .cell_rdata(rdata0), .macro_sel(msel0), .cell_addr(caddr0), .state_we(we0),
      .state_addr(saddr0), .state_data(sdata0), .result(res0), .busy(busy0), .done(done0)
   );

   // Micro-board RAM model: one cycle read latency.
   always @(posedge clk) begin
      rdata1 <= board_mem[msel1][caddr1];
      rdata0 <= board_mem[msel0][caddr0];
   end

   typedef struct {
      logic [8:0][1:0] cells;   // cells[k-1] is cell k
      logic [3:0]      addr;
      logic [1:0]      exp_res;
      int              inj_cyc;
      logic [3:0]      inj_addr;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0][1:0] mk(input logic [1:0] a1, a2, a3, a4, a5, a6, a7, a8, a9);
      logic [8:0][1:0] b;
      b[0] = a1; b[1] = a2; b[2] = a3; b[3] = a4; b[4] = a5;
      b[5] = a6; b[6] = a7; b[7] = a8; b[8] = a9;
      return b;
   endfunction

   // Reference: tic-tac-toe scoring from the board as a 3x3 grid.
   function automatic logic [1:0] ref_eval(input logic [8:0][1:0] b);
      bit w1 = 0, w2 = 0;
      int filled = 0;
      int ln [8][3];
      for (int r = 0; r < 3; r++) begin
         ln[r]     = '{3*r, 3*r+1, 3*r+2};
         ln[3 + r] = '{r, r+3, r+6};
      end
      ln[6] = '{0, 4, 8};
      ln[7] = '{2, 4, 6};
      for (int i = 0; i < 8; i++) begin
         if (b[ln[i][0]] == b[ln[i][1]] && b[ln[i][1]] == b[ln[i][2]]) begin
            if (b[ln[i][0]] == 2'b01) w1 = 1;
            if (b[ln[i][0]] == 2'b10) w2 = 1;
         end
      end
      for (int k = 0; k < 9; k++) if (b[k] != 2'b00) filled++;
      if (w1 && w2) return 2'b11;
      if (w1) return 2'b01;
      if (w2) return 2'b10;
      if (filled == 9) return 2'b11;
      return 2'b00;
   endfunction

   task automatic load_board(input logic [3:0] addr, input logic [8:0][1:0] b);
      for (int k = 1; k <= 9; k++) board_mem[addr][k] = b[k-1];
   endtask

   // Called #1 after a posedge; start goes high for that cycle (cycle 0).
   task automatic run_eval(input string tag, input logic [3:0] addr, input logic [1:0] exp_res,
                           input int inj_cyc, input logic [3:0] inj_addr);
      int dcyc1 = -1, dcyc0 = -1, dcnt1 = 0, dcnt0 = 0;
      int wcyc1 = -1, wcnt1 = 0, wcnt0 = 0;
      int bbad1 = 0, bbad0 = 0, cbad = 0;
      logic [3:0] sa1 = 4'hx;
      logic [1:0] sd1 = 2'bxx, sd0 = 2'bxx;
      start      = 1'b1;
      macro_addr = addr;
      for (int cyc = 1; cyc <= 15; cyc++) begin
         @(posedge clk); #1;
         if (done1) begin dcnt1++; dcyc1 = cyc; end
         if (done0) begin dcnt0++; dcyc0 = cyc; end
         if (we1) begin wcnt1++; wcyc1 = cyc; sa1 = saddr1; sd1 = sdata1; end
         if (we0) begin wcnt0++; sd0 = sdata0; end
         if (busy1 !== (cyc >= 1 && cyc <= 12)) bbad1++;
         if (busy0 !== (cyc >= 1 && cyc <= 12)) bbad0++;
         if (cyc <= 9 && caddr1 !== 4'(cyc)) cbad++;
         if (cyc == inj_cyc) begin
            start      = 1'b1;
            macro_addr = inj_addr;
         end else begin
            start = 1'b0;
         end
      end
      check({tag, " done_cycle"},   32'(dcyc1), 32'd12);
      check({tag, " done_count"},   32'(dcnt1), 32'd1);
      check({tag, " we_cycle"},     32'(wcyc1), 32'd12);
      check({tag, " we_count"},     32'(wcnt1), 32'd1);
      check({tag, " state_addr"},   32'(sa1), 32'(addr));
      check({tag, " state_data"},   32'(sd1), 32'(exp_res));
      check({tag, " result"},       32'(res1), 32'(exp_res));
      check({tag, " busy_window"},  32'(bbad1), 32'd0);
      check({tag, " cell_addr_seq"}, 32'(cbad), 32'd0);
      check({tag, " idle_cell_addr"}, 32'(caddr1), 32'd0);
      check({tag, " wo0 done_cycle"}, 32'(dcyc0), 32'd12);
      check({tag, " wo0 done_count"}, 32'(dcnt0), 32'd1);
      check({tag, " wo0 we_count"},   32'(wcnt0), (exp_res == 2'b00) ? 32'd0 : 32'd1);
      if (exp_res != 2'b00)
         check({tag, " wo0 state_data"}, 32'(sd0), 32'(exp_res));
      check({tag, " wo0 result"},     32'(res0), 32'(exp_res));
      check({tag, " wo0 busy_window"}, 32'(bbad0), 32'd0);
   endtask

   // Out-of-range macro address: done next cycle, nothing else moves.
   task automatic run_invalid(input string tag, input logic [3:0] addr);
      logic [1:0] rb1 = res1, rb0 = res0;
      int dcyc = -1, dcnt = 0, dcnt0 = 0, wcnt = 0, bcnt = 0;
      start      = 1'b1;
      macro_addr = addr;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done1) begin dcnt++; dcyc = cyc; end
         if (done0) dcnt0++;
         if (we1 || we0) wcnt++;
         if (busy1 || busy0) bcnt++;
      end
      check({tag, " done_cycle"}, 32'(dcyc), 32'd1);
      check({tag, " done_count"}, 32'(dcnt), 32'd1);
      check({tag, " wo0 done_count"}, 32'(dcnt0), 32'd1);
      check({tag, " no_write"},   32'(wcnt), 32'd0);
      check({tag, " no_busy"},    32'(bcnt), 32'd0);
      check({tag, " result_held"}, 32'(res1), 32'(rb1));
      check({tag, " wo0 result_held"}, 32'(res0), 32'(rb0));
      check({tag, " cell_addr"},  32'(caddr1), 32'd0);
   endtask

   initial begin
      int dw;
      vec_t v;
      for (int a = 0; a < 16; a++)
         for (int k = 0; k < 16; k++) board_mem[a][k] = 2'b00;

      vecs[0] = '{mk(1,1,1,0,0,0,0,0,0), 4'd5, 2'b01, 4,  4'd7};
      vecs[1] = '{mk(1,0,2,0,2,0,2,0,1), 4'd3, 2'b10, 12, 4'd2};
      vecs[2] = '{mk(1,2,1,1,2,2,2,1,1), 4'd9, 2'b11, 0,  4'd0};
      vecs[3] = '{mk(0,0,0,0,1,0,0,0,0), 4'd1, 2'b00, 0,  4'd0};
      vecs[4] = '{mk(1,1,1,0,0,0,2,2,2), 4'd2, 2'b11, 0,  4'd0};
      vecs[5] = '{mk(0,2,0,1,2,1,0,2,0), 4'd7, 2'b10, 0,  4'd0};
      vecs[6] = '{mk(3,3,3,3,3,3,3,3,3), 4'd4, 2'b11, 0,  4'd0};
      vecs[7] = '{mk(3,3,3,0,0,0,0,0,0), 4'd8, 2'b00, 0,  4'd0};
      vecs[8] = '{mk(1,0,0,0,1,0,0,0,1), 4'd6, 2'b01, 0,  4'd0};
      vecs[9] = '{mk(0,0,0,0,0,0,0,0,0), 4'd9, 2'b00, 0,  4'd0};

      // Reset state
      clear_n    = 1'b0;
      start      = 1'b0;
      macro_addr = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset wo1 outputs", 32'({msel1, caddr1, we1, saddr1, sdata1, res1, busy1, done1}), 32'd0);
      check("reset wo0 outputs", 32'({msel0, caddr0, we0, saddr0, sdata0, res0, busy0, done0}), 32'd0);
      clear_n = 1'b1;

      // Table vectors, first one started on the first edge after reset release
      for (int i = 0; i < 10; i++) begin
         load_board(vecs[i].addr, vecs[i].cells);
         run_eval($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_res,
                  vecs[i].inj_cyc, vecs[i].inj_addr);
      end

      // Invalid addresses after a non-zero result
      run_invalid("bad_addr0", 4'd0);
      run_invalid("bad_addr12", 4'd12);

      // Reset in the middle of an evaluation
      load_board(4'd5, vecs[0].cells);
      start      = 1'b1;
      macro_addr = 4'd5;
      dw = 0;
      for (int cyc = 1; cyc <= 14; cyc++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (cyc == 6) begin
            clear_n = 1'b0;
            #1;
            check("midreset busy", 32'(busy1), 32'd0);
            check("midreset outputs", 32'({msel1, caddr1, we1, saddr1, sdata1, res1, done1}), 32'd0);
         end
         if (cyc == 8) clear_n = 1'b1;
         if (done1 || we1 || done0 || we0) dw++;
      end
      check("midreset no_done_we", 32'(dw), 32'd0);
      run_eval("restart", 4'd5, 2'b01, 0, 4'd0);

      // Random boards against the reference model
      for (int i = 0; i < 30; i++) begin
         v.addr = 4'($urandom_range(1, 9));
         for (int k = 0; k < 9; k++) v.cells[k] = 2'($urandom_range(0, 3));
         load_board(v.addr, v.cells);
         run_eval($sformatf("rnd%0d", i), v.addr, ref_eval(v.cells), 0, 4'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/micro_board_evaluator.md
MICRO_BOARD_EVALUATOR -- requirements
Module: micro_board_evaluator

Interface
REQ-001 Parameter WRITE_ONGOING, default 1: when 1, an "in progress" result (00) is still written to the board-state RAM; when 0, that write is suppressed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clear_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to evaluate one micro board.
REQ-005 macro_addr  input  4  macro cell to evaluate; valid range 1..9.
REQ-006 cell_rdata  input  2  micro-cell content from micro-board RAM; valid 1 cycle after cell_addr is presented.
REQ-007 macro_sel  output  4  latched macro_addr, driven to the micro-board RAM.
REQ-008 cell_addr  output  4  micro-cell address 1..9.
REQ-009 state_we  output  1  one-cycle write strobe to the board-state RAM.
REQ-010 state_addr  output  4  board-state RAM address; equals macro_sel.
REQ-011 state_data  output  2  macro-cell result written to the board-state RAM.
REQ-012 result  output  2  last evaluated result; held until the next evaluation.
REQ-013 busy  output  1  high from the cycle after start is accepted through the WRITE cycle.
REQ-014 done  output  1  one-cycle pulse at the end of every accepted evaluation.

Function
REQ-015 Cell encoding: 00 empty; 01 player 1; 10 player 2; 11 counts as occupied but owned by neither player.
REQ-016 FSM states: IDLE, FETCH, CAPT, EVAL, WRITE.
REQ-017 IDLE: start=1 with macro_addr in 1..9 latches macro_sel, clears the shadow register, enters FETCH, and sets cell_addr=1.
REQ-018 FETCH: lasts 9 cycles; cell_addr steps 1..9, one per cycle; cell_rdata for address k-1 is captured into shadow[k-1].
REQ-019 CAPT: lasts 1 cycle; captures cell 9.
REQ-020 EVAL: registers the result.
REQ-021 Player 1 wins when any of the 8 lines (rows 123, 456, 789; columns 147, 258, 369; diagonals 159, 357) is all 01.
REQ-022 Player 2 wins under the same rule with value 10.
REQ-023 If both players win, the result is 11.
REQ-024 Otherwise, if all 9 cells are non-zero, the result is 11 (draw).
REQ-025 Otherwise, the result is 00.
REQ-026 WRITE: done=1 and state_data=result.
REQ-027 WRITE: state_we=1 unless result=00 and WRITE_ONGOING=0.
REQ-028 WRITE always returns to IDLE.
REQ-029 Latency: start sampled at cycle 0 gives done and state_we at cycle 12; the next start is accepted at cycle 13 at the earliest.
REQ-030 start while busy=1, including the WRITE cycle, is ignored and not queued.
REQ-031 start with macro_addr 0 or 10..15: stays in IDLE, no write, done pulses the next cycle, result unchanged.
REQ-032 state_we, done and busy are never high outside the states defined above.
REQ-033 cell_addr is 0 in IDLE.
REQ-034 state_addr and state_data are stable throughout the state_we cycle.

Reset
REQ-035 clear_n=0 immediately forces IDLE and sets all outputs to 0: macro_sel, cell_addr, state_we, state_addr, state_data, result, busy, done; the shadow register is also zeroed.
REQ-036 Reset mid-evaluation aborts the evaluation with no write and no done pulse.
REQ-037 Deassertion of clear_n is applied on a clock edge; the first start is accepted on the first edge with clear_n=1.

Structure
REQ-038 A shared package holds the result encodings (ONGOING=00, P1=01, P2=10, DRAW=11), the FSM state encoding, the 8-line index table and the cell count of 9.
REQ-039 One combinational sub-module, micro_win_check, maps 9x2 cells to the 2-bit result.
REQ-040 The board-state RAM uses the same micro_win_check sub-module.

Verification
REQ-041 Cells 1,2,3=01, rest 00, macro_addr=5 -> at cycle 12: state_we=1, state_addr=5, state_data=01, done=1.
REQ-042 Diagonal 3,5,7=10, cells 1,9=01 -> state_data=10.
REQ-043 Full board with no line, e.g. 01,10,01,01,10,10,10,01,01 -> state_data=11.
REQ-044 Board with one 01, WRITE_ONGOING=0 -> done=1, state_we=0, result=00; with WRITE_ONGOING=1 -> state_we=1, state_data=00.
REQ-045 Second start at cycle 4 is ignored; macro_addr=0 -> no write, done at cycle 1.
REQ-046 clear_n low at cycle 6 -> no state_we/done, busy=0; a restart after reset completes normally.
